// File: rtl/siso_sched_pkg.sv
// siso_sched_pkg: state encoding and counter sizing shared by the siso_sched block.
package siso_sched_pkg;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    function automatic int cnt_width(input int width, input int depth);
        return (width + depth) > 2 ? $clog2(width + depth) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the index after last.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic          hit;
    logic [IW-1:0] j;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        j = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = IW'((int'(last) + k) % NREQ);
            if (en && !hit && req[j]) begin
                hit = 1'b1;
                idx = j;
            end
        end
        gnt = '0;
        gnt[idx] = hit;
    end

endmodule

// File: rtl/siso_sched.sv
// siso_sched: round-robin scheduler sharing one unreset serial lane among NREQ requesters.
module siso_sched
    import siso_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  sr_din,
    input  logic                  sr_dout,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  busy
);

    localparam int CW = cnt_width(WIDTH, DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(DEPTH);

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    last, win;
    logic [WIDTH-1:0] shreg, word;
    logic             accept;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req  (req_valid),
        .last (last),
        .en   (state == IDLE),
        .gnt  (req_ready),
        .idx  (win)
    );

    assign accept    = |req_ready;
    assign word      = req_data[int'(win)*WIDTH +: WIDTH];
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;

    always_ff @(posedge clk)
        state <= reset ? IDLE : nxt;

    always_comb begin
        nxt = state;
        nxt = accept ? XFER :
              (state == XFER && cnt == CNT_LAST) ? RESP :
              (rsp_valid && rsp_ready) ? IDLE : state;
    end

    // shreg holds the bits still to be sent, so sr_din falls to 0 once the word is out
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            last     <= IW'(NREQ - 1);
            sr_din   <= 1'b0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else if (accept) begin
            shreg  <= word << 1;
            sr_din <= word[WIDTH-1];
            last   <= win;
            rsp_id <= win;
            cnt    <= '0;
        end else if (state == XFER) begin
            shreg  <= shreg << 1;
            sr_din <= shreg[WIDTH-1];
            cnt    <= cnt + CW'(1);
            if (cnt >= CNT_CAP)
                rsp_data <= (rsp_data << 1) | WIDTH'(sr_dout);
        end
    end

endmodule

// File: tb/tb_siso_sched.sv
// tb_siso_sched: directed bench with a response scoreboard, default and minimum-size instances.
module tb_siso_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  req_ready;
    logic        sr_din, sr_dout, rsp_valid, busy;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [3:0]  lane;

    logic [1:0]  b_req_valid = '0;
    logic [1:0]  b_req_data = '0;
    logic        b_rsp_ready = 1'b1;
    logic [1:0]  b_req_ready;
    logic        b_sr_din, b_sr_dout, b_rsp_valid, b_busy, b_lane;
    logic [0:0]  b_rsp_id, b_rsp_data;

    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int   acc_cyc[$];
    int   acc_id[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n_rsp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    siso_sched dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .sr_din(sr_din), .sr_dout(sr_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    siso_sched #(.NREQ(2), .WIDTH(1), .DEPTH(1)) dut_min (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .sr_din(b_sr_din), .sr_dout(b_sr_dout),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
        .rsp_ready(b_rsp_ready), .busy(b_busy)
    );

    // unreset lanes: DEPTH flops for the default instance, one flop for the minimum one
    always @(posedge clk) lane <= {lane[2:0], sr_din};
    always @(posedge clk) b_lane <= b_sr_din;
    assign sr_dout   = lane[3];
    assign b_sr_dout = b_lane;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("req_ready_onehot", 32'($onehot0(req_ready)), 1);
            for (int i = 0; i < 4; i++)
                if (req_ready[i] && req_valid[i]) begin
                    exp_q.push_back({2'(i), req_data[i*8 +: 8]});
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(i);
                end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                chk("rsp_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80 && busy; i++) begin
            adv();
            smp();
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic request(input logic [3:0] v, input logic [3:0] exp_rdy, input string tag);
        adv();
        req_valid = v;
        smp();
        chk(tag, 32'(req_ready), 32'(exp_rdy));
        adv();
        req_valid = '0;
        smp();
        wait_idle({tag, "_drain"});
    endtask

    task automatic b_xfer(input logic [1:0] v, input logic [1:0] d, input logic exp_id,
                          input logic exp_bit, input string tag);
        adv();
        b_req_valid = v;
        b_req_data = d;
        smp();
        chk({tag, "_accept"}, 32'(b_req_ready), 32'(v));
        adv();
        b_req_valid = '0;
        smp();
        chk({tag, "_sr_din"}, 32'(b_sr_din), 32'(exp_bit));
        chk({tag, "_early1"}, 32'(b_rsp_valid), 0);
        adv();
        smp();
        chk({tag, "_early2"}, 32'(b_rsp_valid), 0);
        adv();
        smp();
        chk({tag, "_rsp_valid"}, 32'(b_rsp_valid), 1);
        chk({tag, "_rsp_id"}, 32'(b_rsp_id), 32'(exp_id));
        chk({tag, "_rsp_data"}, 32'(b_rsp_data), 32'(exp_bit));
        adv();
        smp();
        chk({tag, "_idle"}, 32'(b_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int nb, hold_cyc;
        repeat (3) adv();
        smp();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_sr_din", 32'(sr_din), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_min_rsp_valid", 32'(b_rsp_valid), 0);
        adv();
        reset = 1'b0;
        rsp_ready = 1'b1;

        // single request
        req_data = 32'h443322A5;
        pat = 8'hA5;
        adv();
        req_valid = 4'b0001;
        smp();
        chk("single_accept", 32'(req_ready), 32'h1);
        for (int k = 1; k <= 13; k++) begin
            adv();
            if (k == 1) req_valid = '0;
            smp();
            if (k <= 8) begin
                chk("single_sr_din", 32'(sr_din), 32'(pat[7]));
                pat = pat << 1;
            end else
                chk("single_sr_din_zero", 32'(sr_din), 0);
            chk("single_rsp_valid", 32'(rsp_valid), 32'(k == 13));
        end
        chk("single_rsp_id", 32'(rsp_id), 0);
        chk("single_rsp_data", 32'(rsp_data), 32'hA5);
        wait_idle("single_idle");

        // round-robin with all requesters valid
        adv();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        acc_cyc.delete();
        acc_id.delete();
        req_data = 32'h44332211;
        req_valid = 4'hF;
        for (int i = 0; i < 100; i++) begin
            smp();
            if (acc_id.size() >= 5) break;
            adv();
        end
        adv();
        req_valid = '0;
        smp();
        wait_idle("rr_drain");
        chk("rr_accepts", 32'(acc_id.size()), 5);
        for (int i = 0; i < acc_id.size(); i++)
            chk("rr_order", 32'(acc_id[i]), 32'(i % 4));
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 14);

        // response backpressure
        rsp_ready = 1'b0;
        req_data = 32'h4433225A;
        adv();
        req_valid = 4'b0100;
        smp();
        chk("bp_accept", 32'(req_ready), 32'h4);
        adv();
        req_valid = 4'b0101;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (rsp_valid) break;
            adv();
        end
        chk("bp_rsp_rise", 32'(rsp_valid), 1);
        hold_cyc = acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : 0;
        chk("bp_latency", 32'(cyc - hold_cyc), 13);
        for (int i = 0; i < 20; i++) begin
            adv();
            smp();
            chk("bp_valid_held", 32'(rsp_valid), 1);
            chk("bp_id_held", 32'(rsp_id), 2);
            chk("bp_data_held", 32'(rsp_data), 32'h33);
            chk("bp_req_ready_low", 32'(req_ready), 0);
            chk("bp_sr_din_low", 32'(sr_din), 0);
        end
        adv();
        rsp_ready = 1'b1;
        smp();
        chk("bp_handshake", 32'(rsp_valid), 1);
        adv();
        smp();
        chk("bp_next_accept", 32'(req_ready), 32'h1);
        adv();
        req_valid = '0;
        smp();
        wait_idle("bp_drain");

        // reset in the middle of a transfer
        req_data = 32'h443322FF;
        adv();
        req_valid = 4'b0001;
        smp();
        chk("abort_accept", 32'(req_ready), 32'h1);
        adv();
        req_valid = '0;
        repeat (4) adv();
        reset = 1'b1;
        exp_q.delete();
        adv();
        reset = 1'b0;
        smp();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_sr_din", 32'(sr_din), 0);
        nb = n_rsp;
        req_data = 32'h4433223C;
        request(4'b0001, 4'b0001, "reset_accept");
        chk("reset_one_rsp", 32'(n_rsp - nb), 1);

        // pointer wrap and sparse requests
        req_data = 32'h44332211;
        request(4'b1000, 4'b1000, "wrap_grant3");
        request(4'b0010, 4'b0010, "sparse_grant1");
        request(4'b0101, 4'b0100, "sparse_grant2_first");
        request(4'b0101, 4'b0001, "sparse_grant0_next");
        chk("sb_empty", 32'(exp_q.size()), 0);

        // minimum width and latency
        b_xfer(2'b01, 2'b01, 1'b0, 1'b1, "min_one");
        b_xfer(2'b10, 2'b01, 1'b1, 1'b0, "min_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/siso_sched.md
# siso_sched

Round-robin scheduler that shares one unreset serial shift-register lane (depth `DEPTH`) among `NREQ` requesters. Each granted request is a `WIDTH`-bit word. The block serializes the word MSB-first onto the lane's `din`, then deserializes the lane's `dout` after the fixed pipeline delay. It returns the captured word, tagged with the requester id, through a valid/ready response port. It sits between the CDC example's producer logic and the `siso` lane instance and owns all sequencing of that lane.

## Interface
- `NREQ`, default 4: number of requesters, at least 2.
- `WIDTH`, default 8: word width in bits, at least 1.
- `DEPTH`, default 4: lane latency in cycles from `din` to `dout`. This is 4 for the three-stage chain plus its output register.
- `clk`, input, 1: the single clock; everything is sampled on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req_valid`, input, `NREQ`: per-requester request pending.
- `req_data`, input, `NREQ*WIDTH`: requester i's word is at bits `[i*WIDTH +: WIDTH]`.
- `req_ready`, output, `NREQ`: one-hot grant/accept. At most one bit is high.
- `sr_din`, output, 1: registered serial bit driven to the lane input.
- `sr_dout`, input, 1: serial bit returned from the lane output.
- `rsp_valid`, output, 1: response word available.
- `rsp_id`, output, `$clog2(NREQ)`: index of the requester that owns the response.
- `rsp_data`, output, `WIDTH`: captured word.
- `rsp_ready`, input, 1: response consumer accepts.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, XFER, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, select the winner by round-robin. The search starts at index `last+1` (mod `NREQ`), where `last` is the most recently granted index.
  - Drive `req_ready[winner]=1` combinationally. That cycle is the accept cycle T.
  - At the edge ending cycle T: latch the word into a shift register, set `last=winner`, clear the counter, go to XFER, and set `sr_din` to word bit `WIDTH-1`.
- **XFER:** one counter `cnt` runs from 0 to `WIDTH+DEPTH-1`.
  - While `cnt < WIDTH`, `sr_din` carries word bit `WIDTH-1-cnt`.
  - Otherwise `sr_din=0`.
  - When `cnt >= DEPTH`, `sr_dout` is shifted into `rsp_data` LSB-side, so the first captured bit ends up as the MSB.
  - On the last count, go to RESP.
- **RESP:**
  - `rsp_valid=1`, and `rsp_id`/`rsp_data` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake, return to IDLE.
- `sr_din=0` in IDLE and RESP.
- `req_ready` is all-zero outside IDLE.
- `req_valid` deasserting in any state other than IDLE has no effect.
- Grant pointer wrap: after index `NREQ-1`, the search continues at 0.
- Only one requester valid: it wins regardless of the pointer.
- The lane has no reset. The capture window starts exactly at the first driven bit, so stale lane content is never sampled.
- **Reset**, including in the middle of XFER or RESP:
  - Next state is IDLE.
  - `sr_din=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `cnt=0`.
  - `last=NREQ-1`, so requester 0 has first priority.
  - The in-flight word is discarded and no response is issued for it.

## Timing
- Reset values: `req_ready=0`, `sr_din=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `busy=0`.
- `sr_din` carries bits during cycles T+1 through T+WIDTH.
- Lane bit delay: a bit driven in cycle c appears on `sr_dout` in cycle c+DEPTH.
- `sr_dout` is sampled at the edges ending cycles T+1+DEPTH through T+DEPTH+WIDTH.
- `rsp_valid` first rises in cycle T+WIDTH+DEPTH+1, which is 13 cycles after accept at the default parameters.
- RESP handshake in cycle R: IDLE in R+1, and the earliest next accept is cycle R+1.
- Back-to-back throughput: one word per WIDTH+DEPTH+2 cycles.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.

## Structure
- Package `siso_sched_pkg` holds the state enum (IDLE/XFER/RESP) and the counter-width localparam helper, `$clog2(WIDTH+DEPTH)`.
- Sub-module `rr_arbiter`, parameterized by `NREQ`:
  - Inputs: request vector, `last` pointer, enable.
  - Outputs: one-hot grant and its binary index.
  - Purely combinational; the pointer register stays in `siso_sched`.

## Test plan
- **Single request:** reset, then `req_valid=4'b0001` with `req_data[7:0]=8'hA5`, lane modelled by the real `siso`. Required: accept at T; `sr_din` carries 1,0,1,0,0,1,0,1 over T+1..T+8; `rsp_valid` at T+13 with `rsp_id=0`, `rsp_data=8'hA5`.
- **Round-robin:** all four requesters valid continuously with words 8'h11/22/33/44, `rsp_ready=1`. Required: grant order 0,1,2,3,0; each response id matches its data; accepts are 14 cycles apart.
- **Response backpressure:** `rsp_ready=0` for 20 cycles after `rsp_valid` rises. Required: `rsp_valid`/`rsp_id`/`rsp_data` stable throughout, `req_ready=0`, `sr_din=0`; after release, the next accept comes one cycle after the handshake.
- **Reset mid-XFER:** assert `reset` at T+5, then request 8'h3C. Required: no response for the aborted word; the new response is 8'h3C, even though the lane still holds stale bits.
- **Pointer wrap and sparse requests:** after a grant to requester 3, assert only `req_valid[1]`. Required: requester 1 is granted. Then with requesters 0 and 2 valid, requester 2 is granted first.
- **Width/latency extremes:** instantiate with `WIDTH=1`, `DEPTH=1`, and a one-flop lane model. Required: `rsp_valid` at T+3 holding the single bit driven; requests with bit values 1 and 0 each return unchanged.
